// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared types and constants for the AES-128 word loader.
//            FSM state encoding, block geometry, default core latency and a
//            helper that drops one 32-bit word into a 128-bit block.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int WORDS_PER_BLK = 4;
  localparam int AES_LATENCY   = 20;
  localparam int BLK_W         = 128;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_KEY   = 2'd1,
    LOAD_STATE = 2'd2
  } fsm_t;

  // Word 0 is the most-significant word of the block.
  function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0] blk,
                                                input logic [1:0]       idx,
                                                input logic [31:0]      w);
    logic [BLK_W-1:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : aes_valid_pipe
// Purpose  : LATENCY-deep shift register tracking which issued blocks are in
//            flight through the AES core. o_dout is the last stage.
// Ports    : clk    - system clock
//            rst    - synchronous active-low clear
//            i_din  - issue pulse entering the pipe
//            o_dout - issue pulse delayed by LATENCY cycles
//            o_any  - any stage of the pipe holds a pulse
// Revision : 1.0 - initial release
// ============================================================================
module aes_valid_pipe
  import aes_pkg::*;
#(
  parameter int LATENCY = AES_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_dout,
  output logic o_any
);

  logic [LATENCY-1:0] r_pipe;

  generate
    if (LATENCY == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!rst) r_pipe <= '0;
        else      r_pipe <= i_din;
      end
    end else begin : g_shift
      always_ff @(posedge clk) begin
        if (!rst) r_pipe <= '0;
        else      r_pipe <= {r_pipe[LATENCY-2:0], i_din};
      end
    end
  endgenerate

  assign o_dout = r_pipe[LATENCY-1];
  assign o_any  = |r_pipe;

endmodule
`default_nettype wire

// File: rtl/aes_word_loader.sv
`default_nettype none
// ============================================================================
// Module   : aes_word_loader
// Purpose  : Assembles 32-bit stream words into 128-bit key/plaintext blocks
//            for a fully pipelined AES-128 core and flags when the core
//            output carries each block's ciphertext.
// Ports    : clk       - system clock, rising edge
//            rst       - synchronous reset, active-low
//            in_valid  - in_data holds a word
//            in_ready  - word can be accepted (never stalls out of reset)
//            in_data   - payload word, most-significant word first
//            key_keep  - on a frame's first word: 4 state words, reuse key
//            state     - registered plaintext to core
//            key       - registered key to core
//            blk_valid - one-cycle pulse: state/key hold a new block
//            res_valid - core output holds ciphertext issued LATENCY ago
//            busy      - partial frame held or block in flight
// Revision : 1.0 - initial release
// ============================================================================
module aes_word_loader
  import aes_pkg::*;
#(
  parameter int LATENCY = AES_LATENCY,
  parameter int WORD_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              key_keep,
  output logic [BLK_W-1:0]  state,
  output logic [BLK_W-1:0]  key,
  output logic              blk_valid,
  output logic              res_valid,
  output logic              busy
);

  localparam logic [1:0] C_LAST_WORD = 2'(WORDS_PER_BLK - 1);

  fsm_t             r_fsm, w_fsm_nxt;
  logic [1:0]       r_cnt, w_cnt_nxt;
  logic             w_xfer, w_key_we, w_st_we, w_issue;
  logic [BLK_W-1:0] r_key_sh, r_st_sh, r_state, r_key;
  logic             r_blk_valid;
  logic             w_pipe_any;

  assign in_ready = rst;
  assign w_xfer   = in_valid & in_ready;

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_cnt_nxt = r_cnt;
    w_key_we  = 1'b0;
    w_st_we   = 1'b0;
    w_issue   = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (w_xfer) begin
          w_cnt_nxt = 2'd1;
          if (key_keep) begin
            w_st_we   = 1'b1;
            w_fsm_nxt = LOAD_STATE;
          end else begin
            w_key_we  = 1'b1;
            w_fsm_nxt = LOAD_KEY;
          end
        end
      end
      LOAD_KEY: begin
        if (w_xfer) begin
          w_key_we = 1'b1;
          if (r_cnt == C_LAST_WORD) begin
            w_cnt_nxt = 2'd0;
            w_fsm_nxt = LOAD_STATE;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      LOAD_STATE: begin
        if (w_xfer) begin
          w_st_we = 1'b1;
          if (r_cnt == C_LAST_WORD) begin
            w_issue   = 1'b1;
            w_cnt_nxt = 2'd0;
            w_fsm_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      default: begin
        w_fsm_nxt = IDLE;
        w_cnt_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fsm       <= IDLE;
      r_cnt       <= 2'd0;
      r_key_sh    <= '0;
      r_st_sh     <= '0;
      r_state     <= '0;
      r_key       <= '0;
      r_blk_valid <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_cnt       <= w_cnt_nxt;
      r_blk_valid <= w_issue;
      if (w_key_we) r_key_sh <= put_word(r_key_sh, r_cnt, in_data);
      if (w_st_we)  r_st_sh  <= put_word(r_st_sh, r_cnt, in_data);
      // The last state word bypasses the shadow so the block issues on the
      // same edge that accepts it.
      if (w_issue) begin
        r_state <= {r_st_sh[BLK_W-1:32], in_data};
        r_key   <= r_key_sh;
      end
    end
  end

  aes_valid_pipe #(
    .LATENCY (LATENCY)
  ) u_valid_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_din  (r_blk_valid),
    .o_dout (res_valid),
    .o_any  (w_pipe_any)
  );

  assign state     = r_state;
  assign key       = r_key;
  assign blk_valid = r_blk_valid;
  assign busy      = (r_fsm != IDLE) || w_pipe_any || r_blk_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_word_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_word_loader
// Purpose  : Self-checking bench for aes_word_loader. A frame-level driver
//            pushes expected blocks and result times into queues; a monitor
//            on the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_word_loader;

  localparam int LAT = 20;

  typedef struct {
    logic [127:0] st;
    logic [127:0] k;
    int           e;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         key_keep = 1'b0;
  logic [127:0] state, key;
  logic         blk_valid, res_valid, busy;

  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  bit           run = 1'b0;
  bit           partial = 1'b0;
  int           last_issue = -1000;
  logic [127:0] model_key = '0;
  blk_t         exp_blk[$];
  int           exp_res[$];
  blk_t         mb;
  int           mr;
  logic         busy_exp;

  aes_word_loader #(.LATENCY(LAT), .WORD_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_keep  (key_keep),
    .state     (state),
    .key       (key),
    .blk_valid (blk_valid),
    .res_valid (res_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: result timing and issued blocks come only from the queues.
  always @(negedge clk) begin
    if (run) begin
      chk1("in_ready", in_ready, rst);
      busy_exp = partial || (cyc >= last_issue && cyc <= last_issue + LAT);
      chk1("busy", busy, busy_exp);
      while (exp_blk.size() > 0 && exp_blk[0].e < cyc) begin
        mb = exp_blk.pop_front();
        chki("blk_missing_cycle", cyc, mb.e);
      end
      while (exp_res.size() > 0 && exp_res[0] < cyc) begin
        mr = exp_res.pop_front();
        chki("res_missing_cycle", cyc, mr);
      end
      if (blk_valid) begin
        if (exp_blk.size() == 0) begin
          chk1("blk_unexpected", blk_valid, 1'b0);
        end else begin
          mb = exp_blk.pop_front();
          chki("blk_cycle", cyc, mb.e);
          chk("state", state, mb.st);
          chk("key", key, mb.k);
        end
      end
      if (res_valid) begin
        if (exp_res.size() == 0) begin
          chk1("res_unexpected", res_valid, 1'b0);
        end else begin
          mr = exp_res.pop_front();
          chki("res_cycle", cyc, mr);
        end
      end
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic send_word(input logic [31:0] w, input logic kk, input int gap, input bit is_last);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      key_keep = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    key_keep = kk;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    key_keep = 1'($urandom_range(0, 1));
    partial  = !is_last;
    if (is_last) last_issue = cyc;
  endtask

  task automatic send_frame(input bit kk, input logic [127:0] k, input logic [127:0] st,
                            input int maxgap, input int stall_at, input int stall_len);
    int   idx;
    int   gap;
    logic kb;
    blk_t b;
    idx = 0;
    if (!kk) begin
      for (int i = 0; i < 4; i++) begin
        gap = (idx == stall_at) ? stall_len : $urandom_range(0, maxgap);
        kb  = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        send_word(k[127-32*i -: 32], kb, gap, 1'b0);
        idx++;
      end
      model_key = k;
    end
    for (int i = 0; i < 4; i++) begin
      gap = (idx == stall_at) ? stall_len : $urandom_range(0, maxgap);
      kb  = (i == 0 && kk) ? 1'b1 : 1'($urandom_range(0, 1));
      send_word(st[127-32*i -: 32], kb, gap, i == 3);
      idx++;
    end
    b.st = st;
    b.k  = model_key;
    b.e  = last_issue;
    exp_blk.push_back(b);
    exp_res.push_back(last_issue + LAT);
  endtask

  task automatic model_clear();
    exp_blk.delete();
    exp_res.delete();
    partial    = 1'b0;
    last_issue = -1000;
    model_key  = '0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
    model_clear();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_state", state, 128'h0);
    chk("rst_key", key, 128'h0);
    chk1("rst_blk_valid", blk_valid, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [127:0] rk, rs;
    bit           rkk;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    run = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("init_state", state, 128'h0);
    chk("init_key", key, 128'h0);
    chk1("init_blk_valid", blk_valid, 1'b0);
    @(posedge clk); #1;

    // Scenario 6: key_keep frame straight after reset uses key 0.
    send_frame(1'b1, 128'h0, 128'h0, 0, -1, 0);
    idle(LAT + 2);

    // Scenario 1: FIPS-197 key and plaintext.
    send_frame(1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3243f6a8885a308d313198a2e0370734, 0, -1, 0);
    idle(LAT + 2);

    // Scenario 2: full frame then a key_keep frame reusing that key.
    send_frame(1'b0, 128'h000102030405060708090a0b0c0d0e0f,
               128'h00112233445566778899aabbccddeeff, 0, -1, 0);
    send_frame(1'b1, 128'h0, 128'h0, 0, -1, 0);
    idle(LAT + 2);

    // Scenario 3: back-to-back full frames, issues 8 cycles apart.
    send_frame(1'b0, 128'h0, 128'h0, 0, -1, 0);
    send_frame(1'b0, 128'h0, 128'h1, 0, -1, 0);
    idle(LAT + 2);

    // Scenario 4: 5-cycle stall before word 4 of a frame.
    send_frame(1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3243f6a8885a308d313198a2e0370734, 0, 3, 5);
    idle(LAT + 2);

    // Scenario 5a: reset after 6 words, then a full frame.
    for (int i = 0; i < 6; i++) send_word($urandom, (i == 0) ? 1'b0 : 1'b1, 0, 1'b0);
    do_reset();
    idle(3);
    send_frame(1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3243f6a8885a308d313198a2e0370734, 0, -1, 0);
    idle(5);

    // Scenario 5b: reset 5 cycles after an issue; its result must vanish.
    do_reset();
    send_frame(1'b1, 128'h0, 128'h0123456789abcdef0011223344556677, 0, -1, 0);
    send_frame(1'b0, 128'hffeeddccbbaa99887766554433221100,
               128'hdeadbeefcafef00d0badc0de12345678, 0, -1, 0);
    idle(LAT + 2);

    // Key_keep frames back to back: issues and results 4 cycles apart.
    for (int i = 0; i < 4; i++)
      send_frame(1'b1, 128'h0, {$urandom, $urandom, $urandom, $urandom}, 0, -1, 0);
    idle(LAT + 2);

    // Randomised frames with random gaps and key reuse.
    for (int i = 0; i < 30; i++) begin
      rk  = {$urandom, $urandom, $urandom, $urandom};
      rs  = {$urandom, $urandom, $urandom, $urandom};
      rkk = 1'($urandom_range(0, 1));
      send_frame(rkk, rk, rs, $urandom_range(0, 2), -1, 0);
    end
    idle(LAT + 5);

    @(negedge clk);
    chki("blk_queue_drained", exp_blk.size(), 0);
    chki("res_queue_drained", exp_res.size(), 0);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_word_loader.md
Name: aes_word_loader

Overview:
Upstream feeder for the fully pipelined AES-128 core `top`. It accepts 32-bit words over a valid/ready stream and assembles 128-bit key and plaintext blocks. Each completed block is presented to the core's `state`/`key` inputs with a one-cycle issue tag. A LATENCY-deep valid pipe marks the cycle in which the core's `out` carries that block's ciphertext.

Parameters:
LATENCY, 20, core pipeline depth in clk cycles from input sample edge to valid `out`; must match `top`.
WORD_W, 32, input word width; fixed at 32, so 4 words make one 128-bit block.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-low: rst==0 at a rising clk edge resets the block.
in_valid  input  1  word on in_data is valid.
in_ready  output  1  block can accept a word this cycle.
in_data  input  32  payload word; most-significant word of each 128-bit value first.
key_keep  input  1  sampled with the first word of a frame; 1 means the frame is 4 state words and the last key is reused.
state  output  128  plaintext to core `state`; registered.
key  output  128  key to core `key`; registered.
blk_valid  output  1  one-cycle pulse: state/key hold a new block this cycle.
res_valid  output  1  core `out` holds the ciphertext of a block issued LATENCY cycles earlier.
busy  output  1  any block is in flight in the core, or a partial frame is held.

Behaviour:
- Transfer: a word transfers when in_valid && in_ready at a rising edge.
- in_ready: 1 whenever rst==1. The block never stalls; worst-case input rate is 1 word/cycle, well below core throughput.
- Reset values: state=0, key=0, blk_valid=0, res_valid=0, busy=0, in_ready=0 during the reset cycle. The FSM goes to IDLE, the word counter to 0, and the valid pipe is cleared. The stored key is zeroed, so a key_keep frame after reset uses key 0.
- FSM states: IDLE, LOAD_KEY, LOAD_STATE.
  - IDLE, on transfer with key_keep=0: capture the word into key shadow bits [127:96], set cnt=1, go to LOAD_KEY.
  - IDLE, on transfer with key_keep=1: capture the word into state shadow bits [127:96], set cnt=1, go to LOAD_STATE.
  - LOAD_KEY: word n goes to key shadow bits [127-32n -: 32]. On the 4th word go to LOAD_STATE with cnt=0.
  - LOAD_STATE: same packing into the state shadow. On the 4th word return to IDLE and issue.
- Issue:
  - At the edge accepting the last state word, state <= {shadow[127:32], in_data} and key <= key shadow.
  - blk_valid=1 for exactly the following cycle.
  - Output registers hold until the next issue; the core keeps sampling them every cycle, but only blk_valid cycles are meaningful.
- Latency: shortest frame is 4 cycles (key_keep), full frame is 8.
- Valid pipe: a LATENCY-bit shift register fed by blk_valid; res_valid is its last stage, i.e. res_valid(t) = blk_valid(t-LATENCY). Back-to-back issues every 4 cycles must yield res_valid pulses exactly 4 cycles apart.
- busy = (FSM != IDLE) || (|valid_pipe) || blk_valid.
- key_keep is ignored except on the first word of a frame.
- in_valid low mid-frame: hold the FSM state and counter indefinitely; no timeout.
- Reset mid-frame: discard the partial frame and flush the valid pipe. No res_valid may appear for blocks issued before the reset.
- Issue and a new frame's first word in the same cycle: both are legal; the new word goes to the shadow and does not disturb the issued outputs.

Decomposition:
- Package aes_pkg holds:
  - the FSM state enum (IDLE, LOAD_KEY, LOAD_STATE);
  - localparam WORDS_PER_BLK=4;
  - localparam AES_LATENCY=20, used as the LATENCY default.
- One sub-module is natural: aes_valid_pipe (parameterised LATENCY shift register with synchronous active-low clear). The FSM and packing stay in the top of this block.

Test Plan:
1. Send key 2b7e1516 28aed2a6 abf71588 09cf4f3c then state 3243f6a8 885a308d 313198a2 e0370734, with the core in loop -> blk_valid one cycle after word 8; res_valid exactly LATENCY cycles later with out=3925841d02dc09fbdc118597196a0b32.
2. Send key 00010203.. 0c0d0e0f and state 00112233.. ccddeeff, then a key_keep=1 frame of state 0 -> out=69c4e0d86a7b0430d8cdb78070b4c55a, followed 4 cycles later by AES(key 000102..0f, pt 0) from the reused key.
3. Send key 0 and state 0, then key 0 and state 1, with words back-to-back -> res_valid pulses 8 cycles apart; out=66e94bd4ef8a2c3b884cfa59ca342b2e, then 58e2fccefa7e3061367f1d57a4e7455a.
4. Drop in_valid low for 5 cycles after word 3 of a frame -> no blk_valid; the frame completes correctly on resume and the ciphertext matches scenario 1.
5. Assert rst=0 for one cycle after word 6, and separately 5 cycles after an issue -> no blk_valid, no res_valid, busy=0 next cycle; a following full frame produces correct output.
6. Send a key_keep=1 frame immediately after reset with state 0 -> key output = 0, out=66e94bd4ef8a2c3b884cfa59ca342b2e.
